// File: rtl/gf_pkg.sv
// Shared definitions for the limb-serial GF(p) add/sub datapath.
//   OP_ADD / OP_SUB : encoding of the op input
//   gf_state_e      : controller states
//   GF_WIDTH/GF_LIMB: default operand width and limb size
package gf_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int GF_WIDTH = 256;
    localparam int GF_LIMB  = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } gf_state_e;

endpackage

// File: rtl/gf_limb_adder.sv
// One LIMB-bit slice of a ripple chain: {cout, sum} = a + b + cin.
// Purely combinational; any operand inversion is done by the caller.
//   a, b : LIMB-bit unsigned addends
//   cin  : carry in
//   sum  : LIMB-bit sum
//   cout : carry out
module gf_limb_adder #(
    parameter int LIMB = 64
) (
    input  logic [LIMB-1:0] a,
    input  logic [LIMB-1:0] b,
    input  logic            cin,
    output logic [LIMB-1:0] sum,
    output logic            cout
);

    logic [LIMB:0] full;

    assign full        = {1'b0, a} + {1'b0, b} + {{LIMB{1'b0}}, cin};
    assign {cout, sum} = full;

endmodule

// File: rtl/gf_addsub_serial.sv
// Limb-serial modular adder/subtractor over GF(p).
// One LIMB-bit slice per cycle, LSB first, through two chains:
//   add: chain0 = a + b,  chain1 = chain0 - p
//   sub: chain0 = a - b,  chain1 = chain0 + p
// The reduced result is selected from the final carries and registered.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : operands/op valid      in_ready : can accept (IDLE only)
//   op         : 0 = add, 1 = sub
//   a, b, p    : operands and modulus (latched on accept)
//   out_valid  : result valid (DONE)    out_ready: consumer takes result
//   result     : reduced result, held stable while out_valid && !out_ready
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Producers hold valid (and data) until that edge; ready may be
// asserted regardless of valid. Only one transfer per edge: in DONE the
// output handshake completes and the input side is not ready until IDLE.
module gf_addsub_serial
    import gf_pkg::*;
#(
    parameter int WIDTH = GF_WIDTH,
    parameter int LIMB  = GF_LIMB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int NLIMB = WIDTH / LIMB;
    localparam int CNT_W = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NLIMB - 1);

    if (WIDTH % LIMB != 0) begin : g_bad_limb
        $error("gf_addsub_serial: WIDTH must be a multiple of LIMB");
    end

    gf_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             op_q;
    logic [WIDTH-1:0] a_q, b_q, p_q;
    logic             c0_q, c1_q;
    logic [WIDTH-1:0] cand0_q, cand1_q;
    logic [WIDTH-1:0] result_q;

    // Current limb slices and chain operands
    logic [LIMB-1:0]  a_i, b_i, p_i;
    logic [LIMB-1:0]  y0, y1;
    logic [LIMB-1:0]  sum0, sum1;
    logic             cout0, cout1;
    logic [WIDTH-1:0] cand0_nx, cand1_nx;
    logic             pick1;

    assign a_i = a_q[cnt_q*LIMB +: LIMB];
    assign b_i = b_q[cnt_q*LIMB +: LIMB];
    assign p_i = p_q[cnt_q*LIMB +: LIMB];

    // Subtraction is a + ~b + 1; the +1 comes from c0 starting at 1.
    assign y0 = (op_q == OP_SUB) ? ~b_i : b_i;
    assign y1 = (op_q == OP_SUB) ? p_i  : ~p_i;

    gf_limb_adder #(.LIMB(LIMB)) u_chain0 (
        .a    (a_i),
        .b    (y0),
        .cin  (c0_q),
        .sum  (sum0),
        .cout (cout0)
    );

    gf_limb_adder #(.LIMB(LIMB)) u_chain1 (
        .a    (sum0),
        .b    (y1),
        .cin  (c1_q),
        .sum  (sum1),
        .cout (cout1)
    );

    // Candidates with the current limb merged in, so the last limb can be
    // selected in the same cycle it is computed.
    always_comb begin
        cand0_nx = cand0_q;
        cand1_nx = cand1_q;
        cand0_nx[cnt_q*LIMB +: LIMB] = sum0;
        cand1_nx[cnt_q*LIMB +: LIMB] = sum1;
    end

    // add: take a+b-p when a+b overflowed or a+b-p did not borrow.
    // sub: chain0 carry-out of 0 means a<b, so the +p correction is needed.
    assign pick1 = (op_q == OP_SUB) ? ~cout0 : (cout0 | cout1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid && in_ready) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == LAST)        state_d = ST_DONE;
            ST_DONE: if (out_ready)            state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            c0_q     <= 1'b0;
            c1_q     <= 1'b0;
            cand0_q  <= '0;
            cand1_q  <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        p_q   <= p;
                        cnt_q <= '0;
                        c0_q  <= (op == OP_SUB);
                        c1_q  <= (op == OP_ADD);
                    end
                end
                ST_RUN: begin
                    cand0_q <= cand0_nx;
                    cand1_q <= cand1_nx;
                    c0_q    <= cout0;
                    c1_q    <= cout1;
                    if (cnt_q == LAST) begin
                        cnt_q    <= '0;
                        result_q <= pick1 ? cand1_nx : cand0_nx;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
